regfile_scoreboard: RTL and testbench

- Issue-stage hazard controller for the 32x32 register file in the pipelined CPU.
- Keeps a count of outstanding (issued, not yet written back) writes per architectural register.
- Grants or stalls instruction issue against RAW hazards and write-count saturation.
- Retires entries on writeback; supports pipeline flush and keeps stall statistics.

---
 rtl/regfile_scoreboard_if.sv | 27 ++
 rtl/regfile_scoreboard.sv | 102 ++++++++++
 tb/tb_regfile_scoreboard.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Issue and writeback bus between the decode/writeback stages and the register-file scoreboard.
interface regfile_scoreboard_if #(
   parameter int unsigned AW = 5
);
   logic          issue_valid;
   logic          issue_ready;
   logic [AW-1:0] src1_addr;
   logic          src1_en;
   logic [AW-1:0] src2_addr;
   logic          src2_en;
   logic [AW-1:0] dst_addr;
   logic          dst_en;
   logic          wb_valid;
   logic [AW-1:0] wb_addr;

   modport master (
      output issue_valid, src1_addr, src1_en, src2_addr, src2_en, dst_addr, dst_en,
      output wb_valid, wb_addr,
      input  issue_ready
   );

   modport slave (
      input  issue_valid, src1_addr, src1_en, src2_addr, src2_en, dst_addr, dst_en,
      input  wb_valid, wb_addr,
      output issue_ready
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Issue-stage RAW/saturation hazard controller tracking outstanding writes per register.
// Optional macro SB_WB_BYPASS_EN: a same-cycle writeback is credited before the hazard check.
module regfile_scoreboard #(
   parameter int unsigned NREG    = 32,
   parameter int unsigned AW      = 5,
   parameter int unsigned CNT_W   = 2,
   parameter int unsigned STALL_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   regfile_scoreboard_if.slave    sb,
   input  logic                   flush,
   output logic                   busy,
   output logic                   wb_err,
   output logic [STALL_W-1:0]     stall_cnt
);
   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
   localparam logic [STALL_W-1:0] STALL_MAX = '1;

   logic [CNT_W-1:0]   pend_q     [NREG];
   logic [CNT_W-1:0]   pend_d     [NREG];
   logic [CNT_W-1:0]   pend_eff_c [NREG];
   logic               wb_err_q, wb_err_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               raw1_c, raw2_c, sat_c, ready_c, fire_c;

   // Counts seen by the hazard check, optionally crediting this cycle's writeback.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         pend_eff_c[r] = pend_q[r];
`ifdef SB_WB_BYPASS_EN
         if (sb.wb_valid && (sb.wb_addr == AW'(r)) && (pend_q[r] != '0))
            pend_eff_c[r] = pend_q[r] - CNT_W'(1);
`endif
      end
   end

   always_comb begin
      raw1_c  = sb.src1_en && (sb.src1_addr != '0) && (pend_eff_c[sb.src1_addr] != '0);
      raw2_c  = sb.src2_en && (sb.src2_addr != '0) && (pend_eff_c[sb.src2_addr] != '0);
      sat_c   = sb.dst_en  && (sb.dst_addr  != '0) && (pend_eff_c[sb.dst_addr] == CNT_MAX);
      ready_c = !flush && !raw1_c && !raw2_c && !sat_c;
      fire_c  = sb.issue_valid && ready_c;
   end

   assign sb.issue_ready = ready_c;

   always_comb begin
      busy = 1'b0;
      for (int r = 0; r < NREG; r++)
         busy = busy | (pend_q[r] != '0);
   end

   // Next state: issue increments, writeback decrements, flush clears everything.
   always_comb begin
      logic inc;
      logic dec;
      wb_err_d = wb_err_q;
      stall_d  = stall_q;
      inc      = 1'b0;
      dec      = 1'b0;
      for (int r = 0; r < NREG; r++)
         pend_d[r] = pend_q[r];
      pend_d[0] = '0;

      if (flush) begin
         for (int r = 0; r < NREG; r++)
            pend_d[r] = '0;
      end else begin
         for (int r = 1; r < NREG; r++) begin
            inc = fire_c && sb.dst_en && (sb.dst_addr == AW'(r));
            dec = sb.wb_valid && (sb.wb_addr == AW'(r)) && (pend_q[r] != '0);
            if (inc && !dec)
               pend_d[r] = pend_q[r] + CNT_W'(1);
            else if (dec && !inc)
               pend_d[r] = pend_q[r] - CNT_W'(1);
         end
         if (sb.wb_valid && (sb.wb_addr != '0) && (pend_q[sb.wb_addr] == '0))
            wb_err_d = 1'b1;
      end

      if (sb.issue_valid && !ready_c && (stall_q != STALL_MAX))
         stall_d = stall_q + STALL_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++)
            pend_q[r] <= '0;
         wb_err_q <= 1'b0;
         stall_q  <= '0;
      end else begin
         for (int r = 0; r < NREG; r++)
            pend_q[r] <= pend_d[r];
         wb_err_q <= wb_err_d;
         stall_q  <= stall_d;
      end
   end

   assign wb_err    = wb_err_q;
   assign stall_cnt = stall_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios then random traffic vs a count-array model.
module tb_regfile_scoreboard;
   localparam int unsigned NREG    = 32;
   localparam int unsigned AW      = 5;
   localparam int unsigned CNT_W   = 2;
   localparam int unsigned STALL_W = 16;
   localparam int          MAXC    = (1 << CNT_W) - 1;
   localparam int          SMAX    = (1 << STALL_W) - 1;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               flush;
   logic               busy;
   logic               wb_err;
   logic [STALL_W-1:0] stall_cnt;

   regfile_scoreboard_if #(.AW(AW)) sb ();

   regfile_scoreboard #(.NREG(NREG), .AW(AW), .CNT_W(CNT_W), .STALL_W(STALL_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .sb        (sb),
      .flush     (flush),
      .busy      (busy),
      .wb_err    (wb_err),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   int pend [NREG];
   bit m_err;
   int m_stall;
   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      foreach (pend[r]) pend[r] = 0;
      m_err   = 1'b0;
      m_stall = 0;
   endfunction

   // Outstanding writes the issue check should see for register a.
   function automatic int seen(input int a);
      int c = pend[a];
`ifdef SB_WB_BYPASS_EN
      if (sb.wb_valid && (int'(sb.wb_addr) == a) && c > 0) c--;
`endif
      return c;
   endfunction

   function automatic bit model_ready();
      if (flush) return 1'b0;
      if (sb.src1_en && sb.src1_addr != 0 && seen(int'(sb.src1_addr)) > 0) return 1'b0;
      if (sb.src2_en && sb.src2_addr != 0 && seen(int'(sb.src2_addr)) > 0) return 1'b0;
      if (sb.dst_en && sb.dst_addr != 0 && seen(int'(sb.dst_addr)) >= MAXC) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit model_busy();
      foreach (pend[r]) if (pend[r] != 0) return 1'b1;
      return 1'b0;
   endfunction

   // One clock: drive inputs, check at the falling edge, advance the model at the rising edge.
   task automatic step(input bit v, input int s1, input bit s1e, input int s2, input bit s2e,
                       input int d, input bit de, input bit wv, input int wa, input bit fl);
      bit rdy;
      int wbi;
      sb.issue_valid = v;
      sb.src1_addr = AW'(s1);  sb.src1_en = s1e;
      sb.src2_addr = AW'(s2);  sb.src2_en = s2e;
      sb.dst_addr  = AW'(d);   sb.dst_en  = de;
      sb.wb_valid  = wv;       sb.wb_addr = AW'(wa);
      flush        = fl;
      @(negedge clk);
      rdy = model_ready();
      check("issue_ready", 32'(sb.issue_ready), 32'(rdy));
      check("busy",        32'(busy),           32'(model_busy()));
      check("wb_err",      32'(wb_err),         32'(m_err));
      check("stall_cnt",   32'(stall_cnt),      32'(m_stall));
      @(posedge clk);
      if (v && !rdy && m_stall < SMAX) m_stall++;
      if (fl) begin
         foreach (pend[r]) pend[r] = 0;
      end else begin
         wbi = wa % NREG;
         if (wv && wbi != 0) begin
            if (pend[wbi] == 0) m_err = 1'b1;
            else pend[wbi]--;
         end
         if (v && rdy && de && (d % NREG) != 0) pend[d % NREG]++;
      end
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int s1, s2, d, wa;
      model_reset();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // drives inputs while reset is held
      #3 rst = 1'b1;
      @(posedge clk); #1;
      idle();

      // Reset mid-operation: pend[3]=2, a stall and a sticky error pending.
      step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 3, 1, 1, 12, 0);
      step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      idle();
      #2 rst = 1'b0;
      #1;
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_stall", 32'(stall_cnt), 32'd0);
      check("rst_err",   32'(wb_err),    32'd0);
      model_reset();
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      step(1, 3, 1, 3, 1, 3, 1, 0, 0, 0);   // no hazard right after release

      // RAW stall on r5 and its release by writeback.
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      step(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
      step(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
      step(1, 0, 0, 5, 1, 6, 1, 1, 5, 0);
      step(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // Saturation on r7.
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
      step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);

      // Simultaneous issue and writeback on r9, plus an independent instruction.
      step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 9, 1, 1, 9, 0);
      step(1, 4, 1, 0, 0, 4, 1, 0, 0, 0);
      step(1, 9, 1, 0, 0, 0, 0, 1, 9, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // Flush with issue_valid held.
      step(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 10, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 10, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 11, 1, 1, 2, 1);
      step(1, 2, 1, 10, 1, 11, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // Spurious writeback and register zero.
      step(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 1, 0, 1, 1, 0, 0);
      idle();

      // Random traffic over a small register window to provoke hazards.
      for (int i = 0; i < 600; i++) begin
         s1 = $urandom_range(0, 7);
         s2 = $urandom_range(0, 7);
         d  = $urandom_range(0, 7);
         wa = $urandom_range(0, 7);
         if ($urandom_range(0, 3) != 0) begin
            for (int k = 0; k < 8; k++) if (pend[(wa + k) % 8] != 0) begin
               wa = (wa + k) % 8;
               break;
            end
         end
         step(1'($urandom_range(0, 4) != 0), s1, 1'($urandom), s2, 1'($urandom),
              d, 1'($urandom_range(0, 3) != 0), 1'($urandom), wa,
              1'($urandom_range(0, 29) == 0));
      end
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
